// File: rtl/bit_serial_adder_pkg.sv
// Shared state encoding for the bit-serial adder.
package bit_serial_adder_pkg;

   localparam int unsigned StateWidth = 2;

   typedef enum logic [StateWidth-1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_e;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// 1-bit full-adder cell.
module bit_serial_adder_fa (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);

   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, one bit per clock.
// Define SUBTRACT_EN to add the 'sub' port (a - b via ~b and carry-in of 1).
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SUBTRACT_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned         CntWidth = $clog2(WIDTH);
   localparam logic [CntWidth-1:0] CntLast  = CntWidth'(WIDTH - 1);

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    a_sr_q, a_sr_d;
   logic [WIDTH-1:0]    b_sr_q, b_sr_d;
   // Holds the first WIDTH-1 sum bits; the last bit comes straight from the cell.
   logic [WIDTH-2:0]    sum_sr_q, sum_sr_d;
   logic [WIDTH-1:0]    sum_q, sum_d;
   logic                carry_q, carry_d;
   logic                cout_q, cout_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   logic                fa_s, fa_cout;
   logic [WIDTH-1:0]    b_load;
   logic                carry_load;
   logic [WIDTH-1:0]    sum_full;

`ifdef SUBTRACT_EN
   assign b_load     = sub ? ~b : b;
   assign carry_load = sub | cin;
`else
   assign b_load     = b;
   assign carry_load = cin;
`endif

   bit_serial_adder_fa u_fa (
      .A    (a_sr_q[0]),
      .B    (b_sr_q[0]),
      .Cin  (carry_q),
      .S    (fa_s),
      .Cout (fa_cout)
   );

   assign sum_full  = {fa_s, sum_sr_q};
   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign sum       = sum_q;
   assign cout      = cout_q;

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      sum_sr_d = sum_sr_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      cout_d   = cout_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid && in_ready) begin
               a_sr_d  = a;
               b_sr_d  = b_load;
               carry_d = carry_load;
               cnt_d   = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            sum_sr_d = sum_full[WIDTH-1:1];
            carry_d  = fa_cout;
            if (cnt_q == CntLast) begin
               sum_d   = sum_full;
               cout_d  = fa_cout;
               state_d = StDone;
            end else begin
               cnt_d = cnt_q + CntWidth'(1);
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         sum_sr_q <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         cout_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         sum_sr_q <= sum_sr_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         cout_q   <= cout_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder: queued expectations, independent monitor.
module tb_bit_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
`ifdef SUBTRACT_EN
   logic         sub = 1'b0;
`endif
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;

   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           rdy_mode = 0;
   logic [W:0]   exp_q[$];
   int           acc_q[$];

   bit_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SUBTRACT_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: add is a+b+cin; subtract is a-b with cout meaning a >= b.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input logic s);
      int t;
      if (s) begin
         t = (int'(x) - int'(y)) & ((1 << W) - 1);
         return {(x >= y), t[W-1:0]};
      end
      t = int'(x) + int'(y) + int'(c);
      return t[W:0];
   endfunction

   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic s);
      int n = 0;
      a = x;
      b = y;
      cin = c;
`ifdef SUBTRACT_EN
      sub = s;
`endif
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", 0, 1);
      exp_q.push_back(model(x, y, c, s));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_valid();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_valid", out_valid, 1);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      logic       ov_prev = 1'b0;
      logic [W:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            ov_prev = 1'b0;
            continue;
         end
         if (in_valid && in_ready) acc_q.push_back(cyc + 1);
         if (out_valid && !ov_prev) begin
            if (acc_q.size() == 0) check("spurious_valid", 1, 0);
            else check("latency", cyc - acc_q.pop_front(), W);
         end
         ov_prev = out_valid;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("result", {cout, sum}, e);
            end
         end
      end
   end

   initial begin : ready_driver
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [W:0] e;
      int         seen;
      logic [W-1:0] x, y;
      logic       c, s;

      // Asynchronous reset asserted mid-cycle must act immediately.
      #7 rst = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      @(posedge clk);
      #1 rst = 1'b0;

      send(8'h5A, 8'h3C, 1'b0, 1'b0);
      drain();
      check("t2_sum", sum, 8'h96);
      check("t2_cout", cout, 0);

      send(8'hFF, 8'h01, 1'b1, 1'b0);
      drain();
      check("t3_sum", sum, 8'h01);
      check("t3_cout", cout, 1);

      // Back-pressure: result held while new operands wait on in_valid.
      out_ready = 1'b0;
      send(8'hC3, 8'h4E, 1'b1, 1'b0);
      a = 8'h11;
      b = 8'h22;
      cin = 1'b0;
      in_valid = 1'b1;
      wait_valid();
      e = exp_q[0];
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", out_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_result", {cout, sum}, e);
         @(negedge clk);
      end
      exp_q.push_back(model(8'h11, 8'h22, 1'b0, 1'b0));
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("accept_after_handoff", in_ready, 1);
      check("valid_dropped", out_valid, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      drain();

      // Reset during RUN aborts the operation.
      send(8'hA5, 8'h5A, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort_in_ready", in_ready, 1);
      check("abort_out_valid", out_valid, 0);
      check("abort_sum", sum, 0);
      exp_q.delete();
      acc_q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      seen = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort_no_result", seen, 0);
      @(posedge clk);
      #1;
      send(8'h01, 8'h02, 1'b0, 1'b0);
      drain();
      check("t5_sum", sum, 8'h03);

`ifdef SUBTRACT_EN
      send(8'h10, 8'h03, 1'b0, 1'b1);
      drain();
      check("sub1_sum", sum, 8'h0D);
      check("sub1_cout", cout, 1);
      send(8'h03, 8'h10, 1'b1, 1'b1);
      drain();
      check("sub2_sum", sum, 8'hF3);
      check("sub2_cout", cout, 0);
`endif

      // Random back-to-back traffic with random output back-pressure.
      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         c = 1'($urandom);
`ifdef SUBTRACT_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         send(x, y, c, s);
      end
      rdy_mode = 0;
      out_ready = 1'b1;
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
